// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the memory-bus responder: FSM states, default widths, error fill.
package mem_bus_pkg;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 16;
  // Replicated across the data width to form the out-of-range read value.
  localparam logic ERR_FILL_BIT = 1'b1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
endpackage

// File: rtl/mem_bus_responder_if.sv
// Cache-to-memory request bus; the requester holds enables/addr/data until ready.
// addr_err exists only when MEM_BUS_RESP_BOUNDS_CHECK_EN is defined.
interface mem_bus_responder_if
  import mem_bus_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) ();
  logic [DATA_WIDTH-1:0] data_in;
  logic [ADDR_WIDTH-1:0] addr_in;
  logic                  read_enable;
  logic                  write_enable;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  ready;
  logic                  busy;
`ifdef MEM_BUS_RESP_BOUNDS_CHECK_EN
  logic                  addr_err;

  modport master (output data_in, addr_in, read_enable, write_enable,
                  input  data_out, ready, busy, addr_err);
  modport slave  (input  data_in, addr_in, read_enable, write_enable,
                  output data_out, ready, busy, addr_err);
`else
  modport master (output data_in, addr_in, read_enable, write_enable,
                  input  data_out, ready, busy);
  modport slave  (input  data_in, addr_in, read_enable, write_enable,
                  output data_out, ready, busy);
`endif
endinterface

// File: rtl/mem_resp_array.sv
// Single-port word storage: synchronous write, registered read that holds until the next read strobe.
module mem_resp_array
  import mem_bus_pkg::*;
#(
  parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter  int DEPTH      = 1024,
  localparam int IDX_W      = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_we,
  input  logic                  i_re,
  input  logic                  i_fill,
  input  logic [IDX_W-1:0]      i_addr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic [DATA_WIDTH-1:0] o_rdata
);
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rdata;

  // Storage is deliberately not cleared by reset.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= i_fill ? {DATA_WIDTH{ERR_FILL_BIT}} : r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;
endmodule

// File: rtl/mem_bus_responder.sv
// Memory-bus responder: accept a read/write, stall WAIT_STATES cycles, then a one-cycle ready pulse.
// Optional MEM_BUS_RESP_BOUNDS_CHECK_EN flags addr_in >= DEPTH with addr_err instead of wrapping.
module mem_bus_responder
  import mem_bus_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 2
) (
  input logic                  clk,
  input logic                  reset,
  mem_bus_responder_if.slave   bus
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = (WAIT_STATES < 1) ? 1 : $clog2(WAIT_STATES + 1);

  state_t                r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [IDX_W-1:0]      r_idx;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_is_wr;
  logic                  r_err;
  logic                  r_ready;
  logic                  r_busy;
  logic                  r_addr_err;

  logic                  w_req;
  logic                  w_idle;
  logic                  w_in_err;
  logic                  w_fire;
  logic                  w_is_wr;
  logic                  w_err;
  logic [IDX_W-1:0]      w_idx;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic [DATA_WIDTH-1:0] w_rdata;
  logic                  w_unused_addr;

  assign w_req  = bus.read_enable | bus.write_enable;
  assign w_idle = (r_state == IDLE);

`ifdef MEM_BUS_RESP_BOUNDS_CHECK_EN
  generate
    if (IDX_W < ADDR_WIDTH) begin : g_range
      assign w_in_err = |bus.addr_in[ADDR_WIDTH-1:IDX_W];
    end else begin : g_full
      assign w_in_err = 1'b0;
    end
  endgenerate
  assign bus.addr_err = r_addr_err;
`else
  assign w_in_err = 1'b0;
`endif
  assign w_unused_addr = ^bus.addr_in;

  // With zero wait states the array is strobed on the acceptance edge, so use the live inputs.
  assign w_idx   = w_idle ? bus.addr_in[IDX_W-1:0] : r_idx;
  assign w_wdata = w_idle ? bus.data_in : r_wdata;
  assign w_is_wr = w_idle ? bus.write_enable : r_is_wr;
  assign w_err   = w_idle ? w_in_err : r_err;

  // Strobe on the edge that enters RESP; gating with reset makes a reset abort an uncommitted write.
  assign w_fire = !reset &&
                  ((w_idle && w_req && (WAIT_STATES == 0)) ||
                   ((r_state == WAIT) && (r_cnt == CNT_W'(1))));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_wdata    <= '0;
      r_is_wr    <= 1'b0;
      r_err      <= 1'b0;
      r_ready    <= 1'b0;
      r_busy     <= 1'b0;
      r_addr_err <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_req) begin
            r_idx   <= bus.addr_in[IDX_W-1:0];
            r_wdata <= bus.data_in;
            r_is_wr <= bus.write_enable;
            r_err   <= w_in_err;
            r_busy  <= 1'b1;
            r_cnt   <= CNT_W'(WAIT_STATES);
            if (WAIT_STATES == 0) begin
              r_state    <= RESP;
              r_ready    <= 1'b1;
              r_addr_err <= w_in_err;
            end else begin
              r_state <= WAIT;
            end
          end
        end
        WAIT: begin
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            r_state    <= RESP;
            r_ready    <= 1'b1;
            r_addr_err <= r_err;
          end
        end
        RESP: begin
          r_state    <= IDLE;
          r_ready    <= 1'b0;
          r_busy     <= 1'b0;
          r_addr_err <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  mem_resp_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_array (
    .clk     (clk),
    .reset   (reset),
    .i_we    (w_fire & w_is_wr & ~w_err),
    .i_re    (w_fire & ~w_is_wr),
    .i_fill  (w_err),
    .i_addr  (w_idx),
    .i_wdata (w_wdata),
    .o_rdata (w_rdata)
  );

  assign bus.data_out = w_rdata;
  assign bus.ready    = r_ready;
  assign bus.busy     = r_busy;
endmodule

// File: tb/tb_mem_bus_responder.sv
// Directed bench for mem_bus_responder: one instance with 2 wait states, one with 0.
module tb_mem_bus_responder;
  import mem_bus_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   n_assert = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  mem_bus_responder_if #(.DATA_WIDTH(32), .ADDR_WIDTH(16)) bus2 ();
  mem_bus_responder_if #(.DATA_WIDTH(32), .ADDR_WIDTH(16)) bus0 ();

  mem_bus_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .DEPTH(1024), .WAIT_STATES(2)) dut2 (
    .clk(clk), .reset(reset), .bus(bus2.slave));
  mem_bus_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .DEPTH(1024), .WAIT_STATES(0)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0.slave));

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // sel=0 addresses the 2-wait-state instance, sel=1 the 0-wait-state one.
  task automatic drive(input bit sel, input bit re, input bit we,
                       input logic [15:0] addr, input logic [31:0] data);
    if (sel) begin
      bus0.read_enable = re; bus0.write_enable = we; bus0.addr_in = addr; bus0.data_in = data;
    end else begin
      bus2.read_enable = re; bus2.write_enable = we; bus2.addr_in = addr; bus2.data_in = data;
    end
  endtask

  function automatic logic rdy(input bit sel);
    return sel ? bus0.ready : bus2.ready;
  endfunction

  function automatic logic bsy(input bit sel);
    return sel ? bus0.busy : bus2.busy;
  endfunction

  function automatic logic [31:0] rdo(input bit sel);
    return sel ? bus0.data_out : bus2.data_out;
  endfunction

  // One request, latency checked against WAIT_STATES+1; data_out captured in the ready cycle.
  task automatic do_req(input bit sel, input bit re, input bit we, input logic [15:0] addr,
                        input logic [31:0] data, input string tag, output logic [31:0] dout);
    int lat;
    lat  = 99;
    dout = 'x;
    drive(sel, re, we, addr, data);
    for (int k = 1; k <= 20; k++) begin
      step;
      if (rdy(sel) === 1'b1) begin
        lat  = k;
        dout = rdo(sel);
        break;
      end
    end
    chk({tag, " latency"}, lat, sel ? 32'd1 : 32'd3);
    drive(sel, 1'b0, 1'b0, addr, data);
    step;
    chk({tag, " ready drop"}, {31'd0, rdy(sel)}, 32'd0);
    chk({tag, " busy drop"}, {31'd0, bsy(sel)}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    int          lat;

    reset = 1'b1;
    drive(0, 0, 0, 16'h0, 32'h0);
    drive(1, 0, 0, 16'h0, 32'h0);
    step; step;
    reset = 1'b0;
    chk("rst ready ws2", {31'd0, bus2.ready}, 32'd0);
    chk("rst busy ws2",  {31'd0, bus2.busy},  32'd0);
    chk("rst dout ws2",  bus2.data_out,        32'd0);
    chk("rst ready ws0", {31'd0, bus0.ready}, 32'd0);
    chk("rst busy ws0",  {31'd0, bus0.busy},  32'd0);
    chk("rst dout ws0",  bus0.data_out,        32'd0);
`ifdef MEM_BUS_RESP_BOUNDS_CHECK_EN
    chk("rst addr_err",  {31'd0, bus2.addr_err}, 32'd0);
`endif

    // Write with cycle-by-cycle timing: busy from N+1, ready at N+3.
    drive(0, 0, 1, 16'h0010, 32'hCAFEF00D);
    step;
    chk("wr busy N+1",  {31'd0, bus2.busy},  32'd1);
    chk("wr ready N+1", {31'd0, bus2.ready}, 32'd0);
    step;
    chk("wr ready N+2", {31'd0, bus2.ready}, 32'd0);
    step;
    chk("wr ready N+3", {31'd0, bus2.ready}, 32'd1);
    drive(0, 0, 0, 16'h0010, 32'h0);
    step;
    chk("wr ready N+4", {31'd0, bus2.ready}, 32'd0);
    chk("wr busy N+4",  {31'd0, bus2.busy},  32'd0);
    do_req(0, 1, 0, 16'h0010, 32'h0, "rd 0x10", d);
    chk("rd 0x10 data", d, 32'hCAFEF00D);

    // Both enables: write wins, data_out untouched by the write.
    do_req(0, 1, 1, 16'h0005, 32'h12345678, "rw 0x5", d);
    chk("rw 0x5 dout held", d, 32'hCAFEF00D);
    do_req(0, 1, 0, 16'h0005, 32'h0, "rd 0x5", d);
    chk("rd 0x5 data", d, 32'h12345678);

    // Reset on the edge that would commit the write.
    do_req(0, 0, 1, 16'h0007, 32'h11111111, "wr 0x7", d);
    drive(0, 0, 1, 16'h0007, 32'hAAAA5555);
    step; step;
    reset = 1'b1;
    drive(0, 0, 0, 16'h0007, 32'h0);
    step;
    reset = 1'b0;
    chk("abort ready", {31'd0, bus2.ready}, 32'd0);
    chk("abort busy",  {31'd0, bus2.busy},  32'd0);
    step;
    chk("abort ready later", {31'd0, bus2.ready}, 32'd0);
    do_req(0, 1, 0, 16'h0007, 32'h0, "rd 0x7", d);
    chk("rd 0x7 data", d, 32'h11111111);

    // Address/data change mid-WAIT is ignored.
    do_req(0, 0, 1, 16'h0021, 32'h21212121, "wr 0x21", d);
    drive(0, 0, 1, 16'h0020, 32'h0BADBEEF);
    step;
    drive(0, 0, 1, 16'h0021, 32'hDEADDEAD);
    lat = 99;
    for (int k = 2; k <= 20; k++) begin
      step;
      if (bus2.ready === 1'b1) begin
        lat = k;
        break;
      end
    end
    chk("midwait latency", lat, 32'd3);
    drive(0, 0, 0, 16'h0, 32'h0);
    step;
    do_req(0, 1, 0, 16'h0020, 32'h0, "rd 0x20", d);
    chk("rd 0x20 data", d, 32'h0BADBEEF);
    do_req(0, 1, 0, 16'h0021, 32'h0, "rd 0x21", d);
    chk("rd 0x21 data", d, 32'h21212121);

    // Zero wait states: single read, then back-to-back reads with enables held.
    do_req(1, 0, 1, 16'h0001, 32'h0000A001, "ws0 wr 1", d);
    do_req(1, 0, 1, 16'h0002, 32'h0000A002, "ws0 wr 2", d);
    do_req(1, 1, 0, 16'h0001, 32'h0, "ws0 rd 1", d);
    chk("ws0 rd 1 data", d, 32'h0000A001);
    drive(1, 1, 0, 16'h0001, 32'h0);
    step;
    chk("b2b ready 1", {31'd0, bus0.ready}, 32'd1);
    chk("b2b data 1",  bus0.data_out,        32'h0000A001);
    drive(1, 1, 0, 16'h0002, 32'h0);
    step;
    chk("b2b gap", {31'd0, bus0.ready}, 32'd0);
    step;
    chk("b2b ready 2", {31'd0, bus0.ready}, 32'd1);
    chk("b2b data 2",  bus0.data_out,        32'h0000A002);
    drive(1, 0, 0, 16'h0, 32'h0);
    step;
    chk("b2b end", {31'd0, bus0.ready}, 32'd0);

`ifdef MEM_BUS_RESP_BOUNDS_CHECK_EN
    do_req(0, 0, 1, 16'h0000, 32'h0F0F0F0F, "wr 0x0", d);
    drive(0, 1, 0, 16'h0400, 32'h0);
    step; step; step;
    chk("oob ready",    {31'd0, bus2.ready},    32'd1);
    chk("oob addr_err", {31'd0, bus2.addr_err}, 32'd1);
    chk("oob data",     bus2.data_out,           32'hFFFFFFFF);
    drive(0, 0, 0, 16'h0, 32'h0);
    step;
    chk("oob addr_err drop", {31'd0, bus2.addr_err}, 32'd0);
    do_req(0, 0, 1, 16'h0400, 32'h5A5A0400, "oob wr", d);
    do_req(0, 1, 0, 16'h0000, 32'h0, "rd 0x0", d);
    chk("oob wr dropped", d, 32'h0F0F0F0F);
`else
    do_req(0, 0, 1, 16'h0400, 32'h5A5A0400, "wrap wr", d);
    do_req(0, 1, 0, 16'h0000, 32'h0, "rd 0x0", d);
    chk("wrap alias", d, 32'h5A5A0400);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_bus_responder.md
Name: mem_bus_responder

Overview:
- Responder end of the cache-to-memory request bus: accepts single-word read/write requests from the cache controller's memory port (addr, data, read_enable/write_enable).
- Stalls for a programmable number of wait states, then completes with a one-cycle ready pulse.
- Used as the on-chip backing store and bus model behind the cache in the CPU subsystem.

Parameters:
- DATA_WIDTH, 32, word width of data_in/data_out.
- ADDR_WIDTH, 16, width of addr_in (word address).
- DEPTH, 1024, number of stored words; power of two, at most 2**ADDR_WIDTH.
- WAIT_STATES, 2, stall cycles between request acceptance and ready; 0 is legal.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- data_in  input  DATA_WIDTH  write data; held stable by the requester until ready
- addr_in  input  ADDR_WIDTH  word address; held stable until ready
- read_enable  input  1  read request; held until ready
- write_enable  input  1  write request; held until ready
- data_out  output  DATA_WIDTH  read data; valid in the ready cycle; held until the next read completes
- ready  output  1  one-cycle completion pulse
- busy  output  1  high while a request is accepted but not yet completed

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high. All outputs are registered.
- Reset values: ready=0, busy=0, data_out=0, FSM=IDLE, wait counter=0. Array contents are not cleared by reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE: if write_enable or read_enable is high, latch addr_in, data_in and the operation, set busy=1, load counter=WAIT_STATES, then go to WAIT (counter>0) or RESP (counter=0).
- WAIT: decrement the counter each cycle; go to RESP when the counter reaches 1.
- RESP: assert ready for exactly one cycle, clear busy, return to IDLE.
  - Write commits to the array in the RESP cycle.
  - Read updates data_out in the RESP cycle.
- Latency: a request sampled in IDLE at cycle N gives ready=1 in cycle N+1+WAIT_STATES. Throughput is one request per WAIT_STATES+2 cycles.
- Simultaneous read_enable and write_enable: write wins and the read is dropped. No error is raised.
- Held enables: the requester drops its enables in the cycle after ready. If an enable is still high when the FSM is back in IDLE, it is treated as a new request (a back-to-back request is legal).
- Address/data changes while busy are ignored, because the values were latched at acceptance.
- Reset mid-operation: the pending request is aborted; an uncommitted write is not performed, and no ready is issued.
- Address mapping: the array index is addr_in[log2(DEPTH)-1:0]. With bounds checking disabled, upper address bits are ignored (the address space wraps modulo DEPTH).
- Read-after-write to the same address returns the new data. Read of a never-written word returns an undefined value.

Optional Feature:
- Macro: MEM_BUS_RESP_BOUNDS_CHECK_EN.
- When defined: adds output addr_err (1 bit, reset 0).
  - A request with addr_in >= DEPTH still takes the normal latency.
  - In its RESP cycle: ready=1 and addr_err=1 for that one cycle; no write is performed; a read returns data_out = {DATA_WIDTH{1'b1}}.
- When undefined: no addr_err port; all addresses wrap as described above.

Decomposition:
- Package mem_bus_pkg: FSM state enum (IDLE/WAIT/RESP), default DATA_WIDTH/ADDR_WIDTH constants, and the error fill value constant.
- Sub-module mem_resp_array: single-port synchronous storage with a write-enable strobe and registered read port, driven by the FSM in RESP.

Test Plan:
- Reset, then write 0xCAFEF00D to addr 0x0010 with WAIT_STATES=2 -> busy high from cycle N+1, ready pulses at N+3; read back addr 0x0010 -> data_out=0xCAFEF00D with ready.
- WAIT_STATES=0: read request -> ready in the cycle after acceptance; back-to-back reads of addr 1 and 2 with enables held -> two ready pulses 2 cycles apart.
- read_enable and write_enable both high, addr 0x0005, data 0x12345678 -> write performed; subsequent read returns 0x12345678.
- Assert reset during WAIT of a write of 0xAAAA5555 to addr 7 (prior contents 0x11111111) -> no ready pulse, busy=0; later read of addr 7 returns 0x11111111.
- Change addr_in/data_in mid-WAIT -> the write lands at the originally latched address with the original data.
- Bounds checking compiled in, DEPTH=1024: read addr 0x0400 -> ready with addr_err=1 and data_out=0xFFFFFFFF. Bounds checking compiled out: write then read addr 0x0400 -> aliases to addr 0x0000.
